lvda_phase_gen: RTL and testbench

- Upstream stage of the LVDA timing chain. Generates the repeating clock-phase strobes V1, V4, W3, X3, Y3, Z1 from SIM_CLK.
- The gate/phase sequencer consumes these strobes: W3/X3/Y3/Z1 set its latches, and V1/V4 hold them.
- Adds a post-reset settle period, cycle-aligned halt, single-cycle step and an external resync, so downstream latches never see a partial phase cycle.

---
 rtl/lvda_phase_gen_if.sv | 25 ++
 rtl/lvda_phase_gen.sv | 130 +++++++++++++
 tb/tb_lvda_phase_gen.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lvda_phase_gen_if.sv
// Control/strobe bundle between the LVDA phase generator and its controller.
interface lvda_phase_gen_if;
    logic       HALT;
    logic       STEP;
    logic       RESYNC;
    logic       V1;
    logic       V4;
    logic       W3;
    logic       X3;
    logic       Y3;
    logic       Z1;
    logic [3:0] TICK;
    logic       READY;
    logic       HALTED;

    modport master (
        output HALT, STEP, RESYNC,
        input  V1, V4, W3, X3, Y3, Z1, TICK, READY, HALTED
    );

    modport slave (
        input  HALT, STEP, RESYNC,
        output V1, V4, W3, X3, Y3, Z1, TICK, READY, HALTED
    );
endinterface

// File: rtl/lvda_phase_gen.sv
// LVDA phase generator: tick counter with registered one-tick phase strobes,
// post-reset settle, boundary-aligned halt/single-step and resync.
module lvda_phase_gen #(
    parameter int TICKS  = 12,
    parameter int OFF_V1 = 0,
    parameter int OFF_W3 = 2,
    parameter int OFF_X3 = 4,
    parameter int OFF_Y3 = 6,
    parameter int OFF_Z1 = 8,
    parameter int OFF_V4 = 10,
    parameter int SETTLE = 4
) (
    input logic             SIM_CLK,
    input logic             SIM_RST,
    lvda_phase_gen_if.slave bus
);
    localparam int NUM_LANES = 6;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int OFFS [NUM_LANES] = '{OFF_V1, OFF_W3, OFF_X3, OFF_Y3, OFF_Z1, OFF_V4};
    localparam logic [3:0] LAST_TICK = 4'(TICKS - 1);

    if (TICKS < 8 || TICKS > 16) begin : g_bad_ticks
        $error("lvda_phase_gen: TICKS must be within 8..16");
    end
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_chk
        if (OFFS[i] < 0 || OFFS[i] >= TICKS) begin : g_bad_off
            $error("lvda_phase_gen: strobe offset outside the phase cycle");
        end
        for (genvar j = i + 1; j < NUM_LANES; j++) begin : g_dup
            if (OFFS[i] == OFFS[j]) begin : g_bad_dup
                $error("lvda_phase_gen: strobe offsets must be distinct");
            end
        end
    end

    typedef enum logic [2:0] {SETTLE_S, RUN, HALTING, HALTED, STEPPING} state_t;

    state_t               state_q, state_d;
    logic [3:0]           tick_q, tick_d;
    logic [SW-1:0]        settle_q, settle_d;
    logic                 ready_q, ready_d;
    logic                 strobe_en;
    logic                 wrap;
    logic                 settle_done;
    logic [NUM_LANES-1:0] strobe_q;

    assign wrap        = (tick_q == LAST_TICK);
    assign settle_done = (int'(settle_q) >= SETTLE - 1);

    always_comb begin
        state_d   = state_q;
        tick_d    = wrap ? 4'd0 : tick_q + 4'd1;
        settle_d  = settle_q;
        ready_d   = ready_q;
        strobe_en = !bus.RESYNC &&
                    (state_q == RUN || state_q == HALTING || state_q == STEPPING);
        case (state_q)
            SETTLE_S: begin
                if (bus.RESYNC) begin
                    tick_d   = 4'd0;
                    settle_d = '0;
                end else if (wrap) begin
                    if (settle_done) begin
                        settle_d = '0;
                        ready_d  = 1'b1;
                        state_d  = bus.HALT ? HALTED : RUN;
                    end else begin
                        settle_d = settle_q + SW'(1);
                    end
                end
            end
            RUN: begin
                // Resync beats halt, but the halt request is still latched.
                if (bus.RESYNC) begin
                    tick_d = 4'd0;
                    if (bus.HALT) state_d = HALTING;
                end else if (bus.HALT) begin
                    state_d = wrap ? HALTED : HALTING;
                end
            end
            HALTING, STEPPING: begin
                if (bus.RESYNC) tick_d = 4'd0;
                else if (wrap)  state_d = HALTED;
            end
            HALTED: begin
                tick_d = 4'd0;
                if (!bus.HALT)     state_d = RUN;
                else if (bus.STEP) state_d = STEPPING;
            end
            default: begin
                state_d = SETTLE_S;
                tick_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state_q  <= SETTLE_S;
            tick_q   <= 4'd0;
            settle_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            settle_q <= settle_d;
            ready_q  <= ready_d;
        end
    end

    // Lane i strobes in the tick after the counter matches its offset.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            strobe_q <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++)
                strobe_q[i] <= strobe_en && (tick_q == 4'(OFFS[i]));
        end
    end

    assign bus.V1     = strobe_q[0];
    assign bus.W3     = strobe_q[1];
    assign bus.X3     = strobe_q[2];
    assign bus.Y3     = strobe_q[3];
    assign bus.Z1     = strobe_q[4];
    assign bus.V4     = strobe_q[5];
    assign bus.TICK   = tick_q;
    assign bus.READY  = ready_q;
    assign bus.HALTED = (state_q == HALTED);
endmodule

// File: tb/tb_lvda_phase_gen.sv
// Bench for lvda_phase_gen: directed scenarios plus random control traffic,
// all checked against a cycle-level behavioural model.
module tb_lvda_phase_gen;
    localparam int TICKS  = 12;
    localparam int SETTLE = 4;
    localparam int OFFS [6] = '{0, 2, 4, 6, 8, 10};

    logic SIM_CLK = 1'b0;
    logic SIM_RST = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    lvda_phase_gen_if bus();
    lvda_phase_gen dut (.SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .bus(bus));

    always #5 SIM_CLK = ~SIM_CLK;

    // Behavioural model: position in cycle plus mode flags.
    int       e_tick, e_wraps;
    bit       e_settling, e_ready, e_stopped, e_halt_req, e_step;
    bit [5:0] e_str;

    always @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            e_tick = 0; e_wraps = 0; e_settling = 1; e_ready = 0;
            e_stopped = 0; e_halt_req = 0; e_step = 0; e_str = '0;
        end else begin
            bit emit, last;
            emit = !e_settling && !e_stopped && !bus.RESYNC;
            for (int i = 0; i < 6; i++) e_str[i] = emit && (e_tick == OFFS[i]);
            last = (e_tick == TICKS - 1);
            if (e_stopped) begin
                e_tick = 0;
                if (!bus.HALT) e_stopped = 0;
                else if (bus.STEP) begin e_stopped = 0; e_step = 1; end
            end else if (bus.RESYNC) begin
                e_tick = 0;
                if (e_settling) e_wraps = 0;
                else if (bus.HALT) e_halt_req = 1;
            end else begin
                if (!e_settling && bus.HALT) e_halt_req = 1;
                if (!last) e_tick++;
                else begin
                    e_tick = 0;
                    if (e_settling) begin
                        e_wraps++;
                        if (e_wraps >= SETTLE) begin
                            e_settling = 0; e_ready = 1;
                            if (bus.HALT) e_stopped = 1;
                        end
                    end else if (e_halt_req || e_step) begin
                        e_stopped = 1; e_halt_req = 0; e_step = 0;
                    end
                end
            end
        end
    end

    function automatic logic [5:0] dut_str();
        return {bus.V4, bus.Z1, bus.Y3, bus.X3, bus.W3, bus.V1};
    endfunction
    function automatic logic [11:0] dut_vec();
        return {dut_str(), bus.TICK, bus.READY, bus.HALTED};
    endfunction
    function automatic logic [11:0] mdl_vec();
        return {e_str, 4'(e_tick), e_ready, e_stopped};
    endfunction

    task automatic cyc();
        @(posedge SIM_CLK);
        #1;
    endtask

    task automatic test_reset();
        bus.HALT = 0; bus.STEP = 0; bus.RESYNC = 0;
        #1 SIM_RST = 1;
        repeat (2) cyc();
        n_checks++;
        if (dut_vec() !== 12'h000) begin
            n_fail++; $display("FAIL reset_state: got %h want 000", dut_vec());
        end
        n_checks++;
        if (dut_vec() !== mdl_vec()) begin
            n_fail++; $display("FAIL reset_model: got %h want %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_settle_run();
        int cnt[6] = '{default: 0};
        @(negedge SIM_CLK) SIM_RST = 0;
        for (int k = 1; k <= 48; k++) begin
            cyc();
            n_checks++;
            if (dut_str() !== 6'b0 || bus.READY !== (k == 48)) begin
                n_fail++;
                $display("FAIL settle k=%0d: str=%b ready=%b want str=0 ready=%0d",
                         k, dut_str(), bus.READY, k == 48);
            end
        end
        for (int k = 1; k <= 120; k++) begin
            logic [5:0] want;
            cyc();
            for (int i = 0; i < 6; i++) want[i] = ((k % TICKS) == OFFS[i] + 1);
            n_checks++;
            if (dut_str() !== want || bus.TICK !== 4'(k % TICKS)) begin
                n_fail++;
                $display("FAIL run_pattern k=%0d: str=%b tick=%0d want str=%b tick=%0d",
                         k, dut_str(), bus.TICK, want, k % TICKS);
            end
            for (int i = 0; i < 6; i++) cnt[i] += int'(dut_str()[i]);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (cnt[i] != 10) begin
                n_fail++; $display("FAIL run_count lane%0d: got %0d want 10", i, cnt[i]);
            end
        end
    endtask

    task automatic test_halt();
        int  cnt[6] = '{default: 0};
        bit  found = 0;
        for (int k = 0; k < 24 && bus.TICK != 4'd5; k++) cyc();
        bus.HALT = 1; cyc(); bus.HALT = 0;
        n_checks++;
        if (dut_vec() !== mdl_vec()) begin
            n_fail++; $display("FAIL halt_req_model: got %h want %h", dut_vec(), mdl_vec());
        end
        for (int k = 0; k < 20 && !found; k++) begin
            cyc();
            for (int i = 0; i < 6; i++) cnt[i] += int'(dut_str()[i]);
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL halting_model: got %h want %h", dut_vec(), mdl_vec());
            end
            if (bus.HALTED === 1'b1) found = 1;
        end
        n_checks++;
        if (!found || bus.TICK !== 4'd0 || cnt[3] != 1 || cnt[4] != 1 || cnt[5] != 1 ||
            cnt[0] != 0 || cnt[1] != 0 || cnt[2] != 0) begin
            n_fail++;
            $display("FAIL halt_tail: halted=%0d tick=%0d counts=%0d%0d%0d%0d%0d%0d want 1,0,000111",
                     found, bus.TICK, cnt[0], cnt[1], cnt[2], cnt[3], cnt[4], cnt[5]);
        end
        bus.HALT = 1;
        for (int k = 0; k < 30; k++) begin
            cyc();
            n_checks++;
            if (dut_str() !== 6'b0 || bus.TICK !== 4'd0 || bus.HALTED !== 1'b1) begin
                n_fail++;
                $display("FAIL halted_quiet k=%0d: str=%b tick=%0d halted=%b want 0,0,1",
                         k, dut_str(), bus.TICK, bus.HALTED);
            end
        end
    endtask

    task automatic test_step();
        int cnt[6] = '{default: 0};
        bus.STEP = 1; cyc(); bus.STEP = 0;
        n_checks++;
        if (bus.HALTED !== 1'b0 || bus.TICK !== 4'd0) begin
            n_fail++; $display("FAIL step_start: halted=%b tick=%0d want 0,0", bus.HALTED, bus.TICK);
        end
        for (int k = 1; k <= 20; k++) begin
            if (k == 6) bus.STEP = 1;
            cyc();
            bus.STEP = 0;
            for (int i = 0; i < 6; i++) cnt[i] += int'(dut_str()[i]);
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL step_model k=%0d: got %h want %h", k, dut_vec(), mdl_vec());
            end
            if (k == 12) begin
                n_checks++;
                if (bus.HALTED !== 1'b1) begin
                    n_fail++; $display("FAIL step_end: halted=%b want 1", bus.HALTED);
                end
            end
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (cnt[i] != 1) begin
                n_fail++; $display("FAIL step_count lane%0d: got %0d want 1", i, cnt[i]);
            end
        end
    endtask

    task automatic test_resync();
        int cnt[6] = '{default: 0};
        bus.HALT = 0;
        cyc();
        for (int k = 0; k < 24 && bus.TICK != 4'd7; k++) cyc();
        n_checks++;
        if (bus.TICK !== 4'd7) begin
            n_fail++; $display("FAIL resync_wait: tick=%0d want 7", bus.TICK);
        end
        bus.RESYNC = 1; cyc(); bus.RESYNC = 0;
        n_checks++;
        if (bus.TICK !== 4'd0 || dut_str() !== 6'b0) begin
            n_fail++; $display("FAIL resync_now: tick=%0d str=%b want 0,0", bus.TICK, dut_str());
        end
        for (int k = 1; k <= 12; k++) begin
            cyc();
            for (int i = 0; i < 6; i++) cnt[i] += int'(dut_str()[i]);
            n_checks++;
            if (k <= 8 && (bus.Z1 !== 1'b0 || bus.V4 !== 1'b0)) begin
                n_fail++; $display("FAIL resync_suppress k=%0d: z1=%b v4=%b want 0", k, bus.Z1, bus.V4);
            end
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (cnt[i] != 1) begin
                n_fail++; $display("FAIL resync_count lane%0d: got %0d want 1", i, cnt[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 24 && bus.W3 !== 1'b1; k++) cyc();
        #2 SIM_RST = 1;
        #1;
        n_checks++;
        if (dut_vec() !== 12'h000) begin
            n_fail++; $display("FAIL async_reset: got %h want 000", dut_vec());
        end
        #2 SIM_RST = 0;
        for (int k = 1; k <= 49; k++) begin
            cyc();
            n_checks++;
            if (bus.READY !== (k >= 48) || bus.V1 !== (k == 49) ||
                {bus.W3, bus.X3, bus.Y3, bus.Z1, bus.V4} !== 5'b0) begin
                n_fail++;
                $display("FAIL resettle k=%0d: ready=%b str=%b", k, bus.READY, dut_str());
            end
        end
    endtask

    task automatic test_halt_settle();
        bus.HALT = 1;
        SIM_RST = 1; cyc();
        @(negedge SIM_CLK) SIM_RST = 0;
        for (int k = 1; k <= 78; k++) begin
            cyc();
            n_checks++;
            if (dut_str() !== 6'b0 || bus.READY !== (k >= 48) || bus.HALTED !== (k >= 48)) begin
                n_fail++;
                $display("FAIL halt_settle k=%0d: str=%b ready=%b halted=%b", k,
                         dut_str(), bus.READY, bus.HALTED);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 19) == 0) bus.HALT = ~bus.HALT;
            bus.STEP   = ($urandom_range(0, 9) == 0);
            bus.RESYNC = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 499) == 0) begin
                SIM_RST = 1;
                #2;
                n_checks++;
                if (dut_vec() !== 12'h000) begin
                    n_fail++; $display("FAIL rand_reset k=%0d: got %h", k, dut_vec());
                end
                SIM_RST = 0;
            end
            cyc();
            n_checks++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                if (n_fail < 20)
                    $display("FAIL rand_model k=%0d: got %h want %h", k, dut_vec(), mdl_vec());
            end
        end
        bus.STEP = 0; bus.RESYNC = 0;
    endtask

    initial begin
        test_reset();
        test_settle_run();
        test_halt();
        test_step();
        test_resync();
        test_async_reset();
        test_halt_settle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
